// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the multi-channel push-button debouncer.
//   - db_state_e : per-channel debounce FSM state encoding
//   - STATE_W    : width of one packed state field on the debug bus
//   - width_for  : number of bits needed to hold the values 0..max_value
//                  (at least 1), used to size the debounce and hold counters
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    CHK_HIGH    = 2'd1,
    HIGH_STABLE = 2'd2,
    CHK_LOW     = 2'd3
  } db_state_e;

  localparam int STATE_W = 2;

  // Counter sizing helper: $clog2 of the largest value the counter must hold.
  // A counter that only ever holds 0 still needs one bit.
  function automatic int width_for(input int max_value);
    if (max_value < 2) begin
      return 1;
    end
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One push-button channel: 2-flop synchroniser, 4-state debounce FSM,
//   debounce counter and long-press hold counter. All outputs are registered.
//
//   Ports
//     Myclk    in   system clock, rising edge
//     rst      in   asynchronous active-high reset
//     pb_raw   in   raw button level (unsynchronised)
//     db_level out  debounced level
//     db_rise  out  one-cycle pulse when db_level goes 0->1
//     db_fall  out  one-cycle pulse when db_level goes 1->0
//     db_long  out  one-cycle pulse after LONG_COUNT cycles accepted-high
//     state    out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int MAX_COUNT  = 500000,
  parameter int LONG_COUNT = 5000000
) (
  input  logic      Myclk,
  input  logic      rst,
  input  logic      pb_raw,
  output logic      db_level,
  output logic      db_rise,
  output logic      db_fall,
  output logic      db_long,
  output db_state_e state
);

  // Debounce counter only ever holds 0..MAX_COUNT-1; the hold counter must
  // be able to sit at LONG_COUNT once saturated.
  localparam int CNT_W  = width_for(MAX_COUNT - 1);
  localparam int HOLD_W = width_for(LONG_COUNT);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_COUNT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_COUNT);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic              sync_meta;
  logic              pb_s;
  db_state_e         state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nxt;
  logic              level_nxt;
  logic              rise_nxt;
  logic              fall_nxt;
  logic              long_nxt;

  // Next-state and next-output logic. Outputs are computed here and
  // registered below, so db_rise/db_fall land in the same cycle as the
  // db_level change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    level_nxt = db_level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    long_nxt  = 1'b0;

    case (state)
      LOW_STABLE: begin
        if (pb_s) begin
          state_nxt = CHK_HIGH;
          cnt_nxt   = '0;
        end
      end

      CHK_HIGH: begin
        if (!pb_s) begin
          // Bounce: drop back without touching the outputs.
          state_nxt = LOW_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH_STABLE;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          hold_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      HIGH_STABLE: begin
        if (!pb_s) begin
          state_nxt = CHK_LOW;
          cnt_nxt   = '0;
        end
      end

      CHK_LOW: begin
        if (pb_s) begin
          // Bounce while releasing: hold counter keeps running.
          state_nxt = HIGH_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW_STABLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          hold_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = LOW_STABLE;
        cnt_nxt   = '0;
        hold_nxt  = '0;
        level_nxt = 1'b0;
      end
    endcase

    // Hold counter runs while accepted-high. An accepted release this cycle
    // wins, so a long-press pulse can never coincide with or follow db_fall.
    // Saturation means HOLD_FIRE is passed exactly once per press.
    if ((state == HIGH_STABLE || state == CHK_LOW) && !fall_nxt) begin
      if (hold == HOLD_FIRE) begin
        long_nxt = 1'b1;
      end
      if (hold != HOLD_SAT) begin
        hold_nxt = hold + HOLD_ONE;
      end
    end
  end

  always_ff @(posedge Myclk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      pb_s      <= 1'b0;
      state     <= LOW_STABLE;
      cnt       <= '0;
      hold      <= '0;
      db_level  <= 1'b0;
      db_rise   <= 1'b0;
      db_fall   <= 1'b0;
      db_long   <= 1'b0;
    end else begin
      sync_meta <= pb_raw;
      pb_s      <= sync_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      db_level  <= level_nxt;
      db_rise   <= rise_nxt;
      db_fall   <= fall_nxt;
      db_long   <= long_nxt;
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//   N_CH independent push-button debouncers. Each bit of pb_raw is handled by
//   its own debounce_channel; bit i of every output belongs to channel i.
//
//   Ports
//     Myclk     in   system clock, rising edge
//     rst       in   asynchronous active-high reset
//     pb_raw    in   [N_CH]   raw button levels
//     db_level  out  [N_CH]   debounced levels
//     db_rise   out  [N_CH]   one-cycle pulse on accepted press
//     db_fall   out  [N_CH]   one-cycle pulse on accepted release
//     db_long   out  [N_CH]   one-cycle long-press pulse
//     dbg_state out  [2*N_CH] per-channel FSM state, channel i at [2*i +: 2]
// -----------------------------------------------------------------------------
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int MAX_COUNT  = 500000,
  parameter int LONG_COUNT = 5000000
) (
  input  logic                    Myclk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         pb_raw,
  output logic [N_CH-1:0]         db_level,
  output logic [N_CH-1:0]         db_rise,
  output logic [N_CH-1:0]         db_fall,
  output logic [N_CH-1:0]         db_long,
  output logic [STATE_W*N_CH-1:0] dbg_state
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_state_e ch_state;

    debounce_channel #(
      .MAX_COUNT  (MAX_COUNT),
      .LONG_COUNT (LONG_COUNT)
    ) u_ch (
      .Myclk    (Myclk),
      .rst      (rst),
      .pb_raw   (pb_raw[i]),
      .db_level (db_level[i]),
      .db_rise  (db_rise[i]),
      .db_fall  (db_fall[i]),
      .db_long  (db_long[i]),
      .state    (ch_state)
    );

    assign dbg_state[STATE_W*i +: STATE_W] = ch_state;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
//   Directed scenarios plus randomized bouncing stimulus. A behavioural model
//   tracks, per channel, the run length of synchronised samples disagreeing
//   with the accepted level and the number of cycles since the last accepted
//   press; every cycle the DUT outputs are compared with it.
// -----------------------------------------------------------------------------
module tb_multi_debouncer;

  localparam int N  = 4;
  localparam int MC = 4;
  localparam int LC = 10;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_LONG = 2;

  // ---------------- clock / reset ----------------
  logic           Myclk = 1'b0;
  logic           rst   = 1'b1;
  logic [N-1:0]   pb_raw = '0;
  logic [N-1:0]   db_level;
  logic [N-1:0]   db_rise;
  logic [N-1:0]   db_fall;
  logic [N-1:0]   db_long;
  logic [2*N-1:0] dbg_state;

  always #5 Myclk = ~Myclk;

  multi_debouncer #(
    .N_CH       (N),
    .MAX_COUNT  (MC),
    .LONG_COUNT (LC)
  ) dut (
    .Myclk     (Myclk),
    .rst       (rst),
    .pb_raw    (pb_raw),
    .db_level  (db_level),
    .db_rise   (db_rise),
    .db_fall   (db_fall),
    .db_long   (db_long),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw input reaches the qualifier two edges late; a level is accepted once
  // MC+1 consecutive delayed samples disagree with the current level.
  logic [N-1:0] m_d1    = '0;
  logic [N-1:0] m_d2    = '0;
  logic [N-1:0] m_seen  = '0;
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_rise  = '0;
  logic [N-1:0] m_fall  = '0;
  logic [N-1:0] m_long  = '0;
  int           m_streak[N];
  int           m_age[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_streak[i] = 0;
      m_age[i]    = 0;
    end
    forever begin
      @(posedge Myclk or posedge rst);
      if (rst) begin
        m_d1 = '0; m_d2 = '0; m_level = '0;
        m_rise = '0; m_fall = '0; m_long = '0;
        for (int i = 0; i < N; i++) begin
          m_streak[i] = 0;
          m_age[i]    = 0;
        end
      end else begin
        m_seen = m_d2;
        m_d2   = m_d1;
        m_d1   = pb_raw;
        for (int i = 0; i < N; i++) begin
          m_rise[i] = 1'b0;
          m_fall[i] = 1'b0;
          m_long[i] = 1'b0;
          if (m_seen[i] != m_level[i]) m_streak[i]++;
          else m_streak[i] = 0;
          if (m_streak[i] == MC + 1) begin
            m_streak[i] = 0;
            m_level[i]  = ~m_level[i];
            m_rise[i]   = m_level[i];
            m_fall[i]   = ~m_level[i];
            m_age[i]    = 0;
          end else if (m_level[i] && m_age[i] < LC) begin
            m_age[i]++;
            if (m_age[i] == LC) m_long[i] = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard: compare every cycle on the falling edge.
  initial forever begin
    @(negedge Myclk);
    if (chk_en) begin
      check_eq("level", db_level, m_level);
      check_eq("rise",  db_rise,  m_rise);
      check_eq("fall",  db_fall,  m_fall);
      check_eq("long",  db_long,  m_long);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] v);
    @(negedge Myclk);
    pb_raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Myclk);
  endtask

  function automatic logic pick(input int kind, input int ch);
    case (kind)
      K_RISE:  return db_rise[ch];
      K_FALL:  return db_fall[ch];
      default: return db_long[ch];
    endcase
  endfunction

  // Expect a pulse of the given kind on channel ch exactly 'edges' rising
  // edges from now, and nothing on that bit before it.
  task automatic expect_pulse(input int kind, input int ch, input int edges, input string tag);
    for (int e = 1; e <= edges; e++) begin
      @(posedge Myclk);
      #1;
      check_eq(tag, {31'd0, pick(kind, ch)}, {31'd0, (e == edges)});
    end
  endtask

  task automatic pulse_reset();
    @(posedge Myclk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("rst_level", db_level, '0);
    check_eq("rst_rise",  db_rise,  '0);
    check_eq("rst_fall",  db_fall,  '0);
    check_eq("rst_long",  db_long,  '0);
    @(negedge Myclk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int p_tog[N];

  initial begin
    idle(3);
    check_eq("por_level", db_level, '0);
    check_eq("por_rise",  db_rise,  '0);
    check_eq("por_fall",  db_fall,  '0);
    check_eq("por_long",  db_long,  '0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // First cycle after reset release: no pulses.
    @(posedge Myclk);
    #1;
    check_eq("post_rst_pulses", {db_rise, db_fall, db_long}, '0);

    // Clean press on ch0: rise exactly 7 edges later, other bits quiet.
    drive(4'b0001);
    expect_pulse(K_RISE, 0, 7, "r027_rise0");
    check_eq("r027_level_vec", db_level, 4'b0001);
    check_eq("r027_rise_vec",  db_rise,  4'b0001);
    idle(13);
    drive(4'b0000);
    expect_pulse(K_FALL, 0, 7, "r027_fall0");
    idle(15);

    // ch1 bouncing every 2 cycles, then steady high.
    for (int k = 0; k < 4; k++) begin
      drive((k % 2 == 0) ? 4'b0010 : 4'b0000);
      idle(1);
    end
    drive(4'b0010);
    expect_pulse(K_RISE, 1, 7, "r028_rise1");
    drive(4'b0000);
    idle(20);

    // ch2 long press, then release without a second long pulse.
    drive(4'b0100);
    expect_pulse(K_RISE, 2, 7, "r029_rise2");
    expect_pulse(K_LONG, 2, 10, "r029_long2");
    idle(10);
    drive(4'b0000);
    expect_pulse(K_FALL, 2, 7, "r029_fall2");
    idle(20);

    // ch3 release with a bounce inside CHK_LOW before long fires.
    drive(4'b1000);
    expect_pulse(K_RISE, 3, 7, "r030_rise3");
    repeat (4) @(posedge Myclk);
    drive(4'b0000);
    idle(1);
    drive(4'b1000);
    drive(4'b0000);
    idle(25);

    // Reset while ch0 is mid-qualification; ch2 already accepted high.
    drive(4'b0100);
    idle(20);
    drive(4'b0101);
    repeat (4) @(posedge Myclk);
    pulse_reset();
    expect_pulse(K_RISE, 0, 7, "r031_rise0");
    check_eq("r031_rise_vec", db_rise, 4'b0101);
    drive(4'b0000);
    idle(20);

    // Simultaneous press on ch0 and ch2.
    drive(4'b0101);
    expect_pulse(K_RISE, 2, 7, "r032_rise2");
    check_eq("r032_rise_vec", db_rise, 4'b0101);
    drive(4'b0000);
    idle(20);

    // Randomized bouncing with occasional resets.
    for (int seg = 0; seg < 30; seg++) begin
      for (int i = 0; i < N; i++) p_tog[i] = ($urandom_range(0, 2) == 0) ? 35 : 2;
      for (int c = 0; c < 80; c++) begin
        logic [N-1:0] v;
        v = pb_raw;
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 99) < p_tog[i]) v[i] = ~v[i];
        end
        drive(v);
        if ($urandom_range(0, 399) == 0) pulse_reset();
      end
    end

    idle(5);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
